// File: rtl/shift_unit_pipe.sv
// Pipelined RV32I/RV64I/Zbb shift and rotate unit.
// The barrel shifter is split across PIPE_STAGES registers, with valid/ready on both sides.
module shift_unit_pipe #(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  imm_out,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  localparam int LOGX = $clog2(XLEN);
  localparam int P    = PIPE_STAGES;

  localparam logic [1:0] K_LOG = 2'd0;
  localparam logic [1:0] K_ARI = 2'd1;
  localparam logic [1:0] K_ROT = 2'd2;

  function automatic int stage_of(input int b);
    return (b * P) / LOGX;
  endfunction

  function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = (i < 32) ? x[i] : x[31];
    return r;
  endfunction

  // Every op is a right op here; left ops run bit-reversed.
  function automatic logic [XLEN-1:0] shr(
    input logic [XLEN-1:0] d,
    input int              b,
    input logic [1:0]      k
  );
    int sh;
    logic [XLEN-1:0] r;
    sh = 1 << b;
    case (k)
      K_ARI:   r = $signed(d) >>> sh;
      K_ROT:   r = (d >> sh) | (d << (XLEN - sh));
      default: r = d >> sh;
    endcase
    return r;
  endfunction

  logic is_op, is_imm, is_op32, is_imm32;
  logic rtype, word;
  logic [XLEN-1:0] src;
  logic [6:0] fn;
  logic [LOGX-1:0] amt;
  logic f_sll, f_srl, f_sra, f_rol, f_ror;

  assign is_op    = opcode == 7'b0110011;
  assign is_imm   = opcode == 7'b0010011;
  assign is_op32  = (XLEN == 64) && (opcode == 7'b0111011);
  assign is_imm32 = (XLEN == 64) && (opcode == 7'b0011011);
  assign rtype    = is_op | is_op32;
  assign word     = is_op32 | is_imm32;
  assign src      = rtype ? rs2 : imm_out;
  assign amt      = src[LOGX-1:0]
                  & (word ? LOGX'(31) : {LOGX{1'b1}});
  assign fn       = rtype ? func7
                  : ((XLEN == 32) || word) ? imm_out[11:5]
                  : {imm_out[11:6], 1'b0};

  assign f_sll = (func3 == 3'b001) && (fn == 7'b0000000);
  assign f_srl = (func3 == 3'b101) && (fn == 7'b0000000);
  assign f_sra = (func3 == 3'b101) && (fn == 7'b0100000);
  assign f_rol = (func3 == 3'b001) && (fn == 7'b0110000) && rtype;
  assign f_ror = (func3 == 3'b101) && (fn == 7'b0110000);

  logic            d_ill, d_rev;
  logic [1:0]      d_kind;
  logic [XLEN-1:0] d_data, wz, ws, wd;

  always_comb begin
    d_ill  = 1'b1;
    d_kind = K_LOG;
    d_rev  = 1'b0;
    if (is_op || is_imm || is_op32 || is_imm32) begin
      unique case (1'b1)
        f_sll: begin d_ill = 1'b0; d_rev = 1'b1; end
        f_srl: d_ill = 1'b0;
        f_sra: begin d_ill = 1'b0; d_kind = K_ARI; end
        f_rol: begin
          d_ill  = 1'b0;
          d_kind = K_ROT;
          d_rev  = 1'b1;
        end
        f_ror: begin d_ill = 1'b0; d_kind = K_ROT; end
        default: ;
      endcase
    end
    // Word ops widen the low word so the full-width shifter yields the right low 32 bits.
    for (int i = 0; i < XLEN; i++) begin
      wz[i] = (i < 32) ? rs1[i] : 1'b0;
      ws[i] = (i < 32) ? rs1[i] : rs1[31];
      wd[i] = rs1[i % 32];
    end
    d_data = rs1;
    if (word) begin
      if (d_kind == K_ROT) d_data = wd;
      else if (d_kind == K_ARI) d_data = ws;
      else d_data = wz;
    end
    if (d_rev) d_data = bitrev(d_data);
    if (d_ill) d_data = '0;
  end

  logic [P-1:0]            v_q, r_q, w_q, i_q;
  logic [P-1:0][XLEN-1:0]  d_q;
  logic [P-1:0][LOGX-1:0]  a_q;
  logic [P-1:0][1:0]       k_q;
  logic [P-1:0][TAG_W-1:0] t_q;

  logic [P-1:0]            v_i, r_i, w_i, i_i;
  logic [P-1:0][XLEN-1:0]  d_i, d_o;
  logic [P-1:0][LOGX-1:0]  a_i;
  logic [P-1:0][1:0]       k_i;
  logic [P-1:0][TAG_W-1:0] t_i;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    v_i = '0;
    r_i = '0;
    w_i = '0;
    i_i = '0;
    d_i = '0;
    a_i = '0;
    k_i = '0;
    t_i = '0;
    v_i[0] = in_valid;
    d_i[0] = d_data;
    a_i[0] = amt;
    k_i[0] = d_kind;
    r_i[0] = d_rev;
    w_i[0] = word;
    i_i[0] = d_ill;
    t_i[0] = in_tag;
    for (int s = 1; s < P; s++) begin
      v_i[s] = v_q[s-1];
      d_i[s] = d_q[s-1];
      a_i[s] = a_q[s-1];
      k_i[s] = k_q[s-1];
      r_i[s] = r_q[s-1];
      w_i[s] = w_q[s-1];
      i_i[s] = i_q[s-1];
      t_i[s] = t_q[s-1];
    end
    d_o = d_i;
    for (int s = 0; s < P; s++) begin
      for (int b = 0; b < LOGX; b++) begin
        if (stage_of(b) == s && a_i[s][b])
          d_o[s] = shr(d_o[s], b, k_i[s]);
      end
    end
    // Final stage undoes the reversal and widens word results.
    if (r_i[P-1]) d_o[P-1] = bitrev(d_o[P-1]);
    if (w_i[P-1]) d_o[P-1] = sext32(d_o[P-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      r_q <= '0;
      w_q <= '0;
      i_q <= '0;
      d_q <= '0;
      a_q <= '0;
      k_q <= '0;
      t_q <= '0;
    end else if (adv) begin
      v_q <= flush ? '0 : v_i;
      r_q <= r_i;
      w_q <= w_i;
      i_q <= i_i;
      d_q <= d_o;
      a_q <= a_i;
      k_q <= k_i;
      t_q <= t_i;
    end else if (flush) begin
      v_q <= '0;
    end
  end

  assign out_valid = v_q[P-1];
  assign result    = d_q[P-1];
  assign out_tag   = t_q[P-1];
  assign illegal   = i_q[P-1];

  logic unused_bits;
  assign unused_bits = ^{imm_out[XLEN-1:12], rs2[XLEN-1:LOGX],
                         a_q, k_q, r_q, w_q};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench: a 32-bit single-stage unit and a 64-bit three-stage unit
// driven with directed vectors; a negedge monitor pops and compares results.
module tb_shift_unit_pipe;

  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] OPI   = 7'b0010011;
  localparam logic [6:0] OP32  = 7'b0111011;
  localparam logic [6:0] OPI32 = 7'b0011011;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_chk = 0;
  int n_fail = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_illegal;
  logic [31:0] a_rs1, a_rs2, a_imm, a_result;
  logic [6:0] a_opc, a_f7;
  logic [2:0] a_f3;
  logic [4:0] a_tag, a_out_tag;

  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_illegal;
  logic [63:0] b_rs1, b_rs2, b_imm, b_result;
  logic [6:0] b_opc, b_f7;
  logic [2:0] b_f3;
  logic [4:0] b_tag, b_out_tag;

  shift_unit_pipe #(.XLEN(32), .PIPE_STAGES(1), .TAG_W(5)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .rs1(a_rs1), .rs2(a_rs2), .imm_out(a_imm),
    .opcode(a_opc), .func3(a_f3), .func7(a_f7), .in_tag(a_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .result(a_result), .out_tag(a_out_tag), .illegal(a_illegal)
  );

  shift_unit_pipe #(.XLEN(64), .PIPE_STAGES(3), .TAG_W(5)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .rs1(b_rs1), .rs2(b_rs2), .imm_out(b_imm),
    .opcode(b_opc), .func3(b_f3), .func7(b_f7), .in_tag(b_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .result(b_result), .out_tag(b_out_tag), .illegal(b_illegal)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_a(input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] imm,
                        input logic [4:0] tag, input logic [31:0] er,
                        input logic eill, input bit push);
    exp_t e;
    bit ok;
    ok = 0;
    a_opc = opc; a_f3 = f3; a_f7 = f7;
    a_rs1 = r1; a_rs2 = r2; a_imm = imm; a_tag = tag;
    a_in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (a_in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL a_in_ready_timeout: tag %0d never accepted", tag);
    end else if (push) begin
      e.res = {32'h0, er}; e.tag = tag; e.ill = eill;
      qa.push_back(e);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [63:0] r1,
                        input logic [63:0] r2, input logic [63:0] imm,
                        input logic [4:0] tag, input logic [63:0] er,
                        input logic eill, input bit push);
    exp_t e;
    bit ok;
    ok = 0;
    b_opc = opc; b_f3 = f3; b_f7 = f7;
    b_rs1 = r1; b_rs2 = r2; b_imm = imm; b_tag = tag;
    b_in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (b_in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL b_in_ready_timeout: tag %0d never accepted", tag);
    end else if (push) begin
      e.res = er; e.tag = tag; e.ill = eill;
      qb.push_back(e);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_pending", 64'(qa.size() + qb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_unexpected: got tag %0d expected no output",
                 a_out_tag);
      end else begin
        e = qa.pop_front();
        chk("a_result", {32'h0, a_result}, e.res);
        chk("a_tag", 64'(a_out_tag), 64'(e.tag));
        chk("a_illegal", 64'(a_illegal), 64'(e.ill));
      end
    end
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected: got tag %0d expected no output",
                 b_out_tag);
      end else begin
        e = qb.pop_front();
        chk("b_result", b_result, e.res);
        chk("b_tag", 64'(b_out_tag), 64'(e.tag));
        chk("b_illegal", 64'(b_illegal), 64'(e.ill));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    a_rs1 = 0; a_rs2 = 0; a_imm = 0; a_opc = 0; a_f3 = 0; a_f7 = 0;
    a_tag = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 1;
    b_rs1 = 0; b_rs2 = 0; b_imm = 0; b_opc = 0; b_f3 = 0; b_f7 = 0;
    b_tag = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_result", {32'h0, a_result}, 64'd0);
    chk("rst_a_tag", 64'(a_out_tag), 64'd0);
    chk("rst_a_illegal", 64'(a_illegal), 64'd0);
    chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_b_valid", 64'(b_out_valid), 64'd0);
    chk("rst_b_result", b_result, 64'd0);
    chk("rst_b_tag", 64'(b_out_tag), 64'd0);
    chk("rst_b_illegal", 64'(b_illegal), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send_a(OP, 3'b101, 7'h20, 32'h80000010, 32'h24, 0, 3, 32'hF8000001, 0, 1);
    send_a(OP, 3'b101, 7'h30, 32'h000000F1, 32'h4, 0, 4, 32'h1000000F, 0, 1);
    send_a(OP, 3'b000, 7'h00, 32'h00001234, 32'h1, 0, 7, 32'h0, 1, 1);
    send_a(OPI32, 3'b001, 7'h00, 32'h1, 0, 32'h1F, 8, 32'h0, 1, 1);
    send_a(OPI, 3'b001, 7'h00, 32'hDEADBEEF, 0, 0, 9, 32'hDEADBEEF, 0, 1);
    send_a(OP, 3'b001, 7'h30, 32'h80000001, 32'h1, 0, 10, 32'h3, 0, 1);
    send_a(OPI, 3'b101, 7'h00, 32'h80000000, 0, 32'h1F, 11, 32'h1, 0, 1);
    send_a(OPI, 3'b101, 7'h00, 32'h12345678, 0, 32'h608, 12, 32'h78123456, 0, 1);
    send_a(OPI, 3'b001, 7'h00, 32'h1, 0, 32'h601, 13, 32'h0, 1, 1);
    send_a(OP, 3'b001, 7'h00, 32'h40000001, 32'h21, 0, 14, 32'h80000002, 0, 1);
    send_a(OPI, 3'b101, 7'h00, 32'h80000000, 0, 32'h420, 15, 32'h0, 1, 1);

    send_b(OPI, 3'b101, 7'h00, 64'h8000000000000000, 0, 64'h420, 1,
           64'hFFFFFFFF80000000, 0, 1);
    send_b(OPI32, 3'b001, 7'h00, 64'h1, 0, 64'h1F, 2,
           64'hFFFFFFFF80000000, 0, 1);
    send_b(OP32, 3'b101, 7'h00, 64'hFFFFFFFF80000000, 64'h24, 0, 3,
           64'h0000000008000000, 0, 1);
    send_b(OP32, 3'b101, 7'h20, 64'h0000000080000000, 64'h8, 0, 4,
           64'hFFFFFFFFFF800000, 0, 1);
    send_b(OPI32, 3'b101, 7'h00, 64'h1, 0, 64'h601, 5,
           64'hFFFFFFFF80000000, 0, 1);
    send_b(OP32, 3'b001, 7'h30, 64'h00000000C0000000, 64'h1, 0, 6,
           64'hFFFFFFFF80000001, 0, 1);
    send_b(OP, 3'b101, 7'h30, 64'h1, 64'h1, 0, 7,
           64'h8000000000000000, 0, 1);
    send_b(OP, 3'b001, 7'h00, 64'h1, 64'h7F, 0, 8,
           64'h8000000000000000, 0, 1);
    send_b(OPI32, 3'b101, 7'h00, 64'h0000000080000001, 0, 0, 9,
           64'hFFFFFFFF80000001, 0, 1);
    send_b(OPI, 3'b101, 7'h00, 64'hFFFFFFFFFFFFFFFF, 0, 64'h3F, 10,
           64'h1, 0, 1);
    send_b(OPI32, 3'b001, 7'h00, 64'h1, 0, 64'h20, 11, 64'h0, 1, 1);
    send_b(OPI32, 3'b001, 7'h00, 64'h1, 0, 64'h601, 12, 64'h0, 1, 1);
    send_b(OP, 3'b001, 7'h30, 64'h8000000000000001, 64'h1, 0, 13,
           64'h3, 0, 1);
    drain();

    // Flush while two ops are in flight and a third is offered.
    send_b(OPI, 3'b001, 7'h00, 64'h1, 0, 64'h1, 20, 0, 0, 0);
    send_b(OPI, 3'b001, 7'h00, 64'h2, 0, 64'h1, 21, 0, 0, 0);
    b_in_valid = 1'b1; b_flush = 1'b1; b_tag = 22;
    a_in_valid = 1'b1; a_flush = 1'b1; a_tag = 23;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_flush = 1'b0;
    a_in_valid = 1'b0; a_flush = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("flush_b_valid", 64'(b_out_valid), 64'd0);
      chk("flush_a_valid", 64'(a_out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Back-to-back ops with a three-cycle output stall.
    fork
      begin
        for (int t = 1; t <= 5; t++)
          send_b(OPI, 3'b001, 7'h00, 64'(t), 0, 64'h4, 5'(t),
                 64'(t) << 4, 0, 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 b_out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(b_in_ready), 64'd0);
          chk("stall_valid", 64'(b_out_valid), 64'd1);
          chk("stall_tag", 64'(b_out_tag), 64'd1);
          chk("stall_result", b_result, 64'h10);
        end
        @(posedge clk);
        #1 b_out_ready = 1'b1;
      end
    join
    drain();

    // Reset together with flush while an op is in flight.
    send_b(OPI, 3'b001, 7'h00, 64'h3, 0, 64'h2, 25, 0, 0, 0);
    rst = 1'b1; b_flush = 1'b1; a_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstfl_valid", 64'(b_out_valid), 64'd0);
    chk("rstfl_result", b_result, 64'd0);
    chk("rstfl_tag", 64'(b_out_tag), 64'd0);
    chk("rstfl_illegal", 64'(b_illegal), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; b_flush = 1'b0; a_flush = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(b_out_valid), 64'd0);
    end
    @(posedge clk); #1;
    chk("final_queue", 64'(qa.size() + qb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle 32-bit shifter in the execute stage.
- Decodes RV32I/RV64I shift instructions, shift-word variants (RV64 only) and Zbb rotates.
- Splits the log-stage barrel shifter across PIPE_STAGES register stages.
- Carries a tag per operation and uses valid/ready handshakes on both sides, so execute can stall or flush it.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; LOGX = log2(XLEN).
PIPE_STAGES, 1, number of register stages, 1..LOGX; shift-amount bit b is applied in stage floor(b*PIPE_STAGES/LOGX).
TAG_W, 5, width of the sideband tag (e.g. rd index) carried with each operation.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous kill of all in-flight operations
in_valid  in  1  operation offered
in_ready  out  1  unit accepts operation this cycle
rs1  in  XLEN  operand to shift
rs2  in  XLEN  R-type shift-amount source
imm_out  in  XLEN  decoded immediate (I-type shamt and funct field)
opcode  in  7  instruction opcode
func3  in  3  instruction funct3
func7  in  7  instruction funct7
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  XLEN  shifted value
out_tag  out  TAG_W  tag of result
illegal  out  1  operation did not decode as a supported shift

Behaviour:
- Opcodes: OP 0110011, OP-IMM 0010011, OP-32 0111011, OP-IMM-32 0011011. The two -32 opcodes are legal only when XLEN=64.
- Shift amount:
  - R-type: rs2[LOGX-1:0].
  - I-type: imm_out[LOGX-1:0].
  - Word variants: [4:0] of the same source.
- Function field:
  - R-type: func7.
  - I-type, XLEN=32 or word: imm_out[11:5].
  - I-type, XLEN=64 non-word: {imm_out[11:6], 1'b0}, compared as funct7.
- Decode by func3 and function field:
  - 001 with 0000000: SLL.
  - 101 with 0000000: SRL.
  - 101 with 0100000: SRA.
  - 001 with 0110000: ROL, R-type only.
  - 101 with 0110000: ROR or RORI.
  - Rotates: not legal as word-immediate except RORIW; RORW/ROLW are legal under OP-32.
  - Anything else, including any func3 other than 001/101: illegal=1 and result=0, still pipelined with its tag.
- Word ops: operate on rs1[31:0] with a 5-bit amount, then sign-extend bit 31 of the 32-bit result to 64 bits.
- Datapath:
  - Decode is combinational at the input.
  - Each stage applies its shift-amount bits (logical, arithmetic or rotate) and registers data, remaining amount bits, op, tag, illegal and valid.
  - Latency is exactly PIPE_STAGES cycles from the accepting edge to out_valid, with no stall.
- Handshake:
  - adv = !out_valid | out_ready; in_ready = adv.
  - When adv=1 all stages shift forward one position, and the input is captured if in_valid.
  - When adv=0 all stage registers hold.
  - Bubbles propagate as valid=0; bubbles are not collapsed.
  - result/out_tag/illegal hold stable while out_valid=1 and out_ready=0.
- Throughput: one operation per cycle when out_ready is held high.
- flush:
  - Clears every stage valid bit at the edge.
  - An in_valid presented in the same cycle is dropped.
  - in_ready is still driven as adv.
- rst has priority over flush. Reset values: all stage valid=0, out_valid=0, result=0, out_tag=0, illegal=0.
- Reset or flush mid-operation discards all in-flight operations; nothing is emitted afterwards for them.
- Shift amount 0 returns rs1 unchanged, or the sign-extended low word for word ops.
- Amount bits above LOGX (or above 5 for word ops) are ignored.

Test Plan:
- XLEN=32, PIPE_STAGES=1: OP SRA with rs1=0x80000010, rs2=0x24 (amount 4) -> one cycle later out_valid=1, result=0xF8000001, illegal=0.
- XLEN=64, PIPE_STAGES=3: SRAI, imm_out=0x420 (funct6 010000, shamt 32), rs1=0x8000_0000_0000_0000 -> after 3 cycles result=0xFFFF_FFFF_8000_0000; SLLIW with rs1=0x1, shamt 31 -> result=0xFFFF_FFFF_8000_0000.
- ROR with rs1=0x0000_00F1, rs2=4, XLEN=32 -> result=0x1000_000F. OP func3=000 -> illegal=1, result=0, tag preserved.
- PIPE_STAGES=3, 5 back-to-back ops with tags 1..5, out_ready low for cycles 4-6 -> in_ready=0 during the stall, outputs held, tags emerge in order 1..5 with no loss or duplication.
- Two ops in flight, flush=1 in the same cycle as a third in_valid -> no out_valid for any of the three. rst asserted together with flush -> all outputs zero on the next edge.
- XLEN=32, OP-IMM-32 opcode -> illegal=1. Shift amount 0 -> result equals rs1.
